operand_skew_feeder: RTL

OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

---
 rtl/operand_skew_feeder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: accepts LANES-wide vectors and delays lane j by j cycles so a
// systolic PE array edge sees a diagonal wavefront. Optional stall counter: FEEDER_STALL_CNT_EN.
module operand_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int LEN_W      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0] in_data_i,
  input  logic                        stall_i,
  output logic [LANES*DATA_WIDTH-1:0] out_data_o,
  output logic [LANES-1:0]            out_lane_vld_o,
  output logic                        busy_o,
  output logic                        done_o
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt_o
`endif
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Handshake: a vector moves when in_valid_i && in_ready_o at a rising edge;
  // in_ready_o never depends on in_valid_i, only on state and stall_i.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [LEN_W-1:0]   rem_cnt;
  logic [CNT_W-1:0]   drain_cnt;
  logic               accept;
  logic               start_ok;
  logic               last_accept;

  assign accept      = (state == STREAM) && in_valid_i && !stall_i;
  assign start_ok    = (state == IDLE) && start_i && !stall_i;
  assign last_accept = accept && (rem_cnt == LEN_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          next_state = (len_i == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        // A single-lane array has nothing to drain after the last vector.
        if (last_accept) begin
          next_state = (LANES == 1) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (!stall_i && (drain_cnt <= CNT_W'(1))) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready_o = (state == STREAM) && !stall_i;
    busy_o     = (state != IDLE);
    done_o     = (state == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_ok) begin
        rem_cnt <= len_i;
      end else if (accept) begin
        rem_cnt <= rem_cnt - LEN_W'(1);
      end

      if (last_accept) begin
        drain_cnt <= CNT_W'(LANES - 1);
      end else if ((state == DRAIN) && !stall_i && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - CNT_W'(1);
      end
    end
  end

  // Lane j owns a (j+1)-deep pipe; stage 0 loads on accept, otherwise a bubble.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] sd [0:j];
    logic                  sv [0:j];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int k = 0; k <= j; k++) begin
          sd[k] <= '0;
          sv[k] <= 1'b0;
        end
      end else if (!stall_i) begin
        sd[0] <= accept ? in_data_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        sv[0] <= accept;
        for (int k = 1; k <= j; k++) begin
          sd[k] <= sd[k-1];
          sv[k] <= sv[k-1];
        end
      end
    end

    assign out_data_o[j*DATA_WIDTH +: DATA_WIDTH] = sv[j] ? sd[j] : '0;
    assign out_lane_vld_o[j]                      = sv[j];
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (start_ok) begin
      stall_cnt_o <= '0;
    end else if (busy_o && stall_i && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
